// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams WORD-bit slices of a WORD*WORDS-bit operand pair
// through one external combinational adder, LSW first, with the carry chained through a register.
module mp_add_sequencer #(
    parameter int WORD  = 32,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD*WORDS-1:0] a,
    input  logic [WORD*WORDS-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    input  logic                  abort,
    output logic [WORD-1:0]       add_a,
    output logic [WORD-1:0]       add_b,
    output logic                  add_cin,
    input  logic [WORD-1:0]       add_y,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  ovf,
    output logic                  zero
);

    localparam int W  = WORD * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            a_msb;
    logic            b_msb;
    logic [W-1:0]    b_eff;
    logic [W-1:0]    sum_next;

    assign b_eff    = sub ? ~b : b;
    // The word arriving this cycle enters at the top; after WORDS shifts the LSW sits at bit 0.
    assign sum_next = {add_y, acc[W-1:WORD]};

    assign in_ready = (state == IDLE);
    assign add_a    = a_q[WORD-1:0];
    assign add_b    = b_q[WORD-1:0];
    assign add_cin  = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        a_msb <= a[W-1];
                        b_msb <= b_eff[W-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        acc   <= sum_next;
                        a_q   <= a_q >> WORD;
                        b_q   <= b_q >> WORD;
                        carry <= add_cout;
                        idx   <= idx + IW'(1);
                        if (idx == IW'(WORDS - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            sum       <= sum_next;
                            cout      <= add_cout;
                            ovf       <= (a_msb == b_msb) && (sum_next[W-1] != a_msb);
                            zero      <= (sum_next == '0);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
